pipe_forward_tracker: RTL
=========================

# pipe_forward_tracker

Parametrised result-tracking and forwarding block for the dual-issue execution pipes, the successor to the fixed even/odd forwarding shift registers. It holds every in-flight instruction's destination tag and result in a LANES × DEPTH shift register. It accepts results from execution units at their completion stage and presents registered write-back per lane. It also resolves NUM_SRC operand lookups per cycle into a forward hit, a register-file fallback, or a RAW hazard for issue logic.

## Interface
- LANES, 2: issue lanes (lane 0 = even, lane 1 = odd); a higher lane index is younger within a cycle.
- DEPTH, 7: tracked stages, 0..DEPTH-1; DEPTH ≥ 2.
- DATA_W, 128: result width.
- ADDR_W, 7: register address width.
- NUM_SRC, 6: operand lookup ports.
- FLUSH_STAGE, 2: stages 0..FLUSH_STAGE-1 are killed by flush; 1 ≤ FLUSH_STAGE ≤ DEPTH.
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- iss_valid  in  LANES  instruction issued on lane
- iss_addr  in  LANES×ADDR_W  destination register
- iss_write  in  LANES  instruction writes the register file
- ins_valid  in  LANES  unit result delivered on lane
- ins_stage  in  LANES×$clog2(DEPTH)  stage of the target entry this cycle
- ins_data  in  LANES×DATA_W  result value
- flush  in  1  branch kill
- src_addr  in  NUM_SRC×ADDR_W  operand address
- src_rf_data  in  NUM_SRC×DATA_W  register-file value
- src_data  out  NUM_SRC×DATA_W  resolved operand
- src_fwd  out  NUM_SRC  operand taken from tracker
- src_hazard  out  NUM_SRC  youngest producer not yet ready
- wb_valid  out  LANES  write-back strobe
- wb_addr  out  LANES×ADDR_W
- wb_data  out  LANES×DATA_W
- wb_error  out  1  sticky: entry reached write-back unready

## Operation
- Entry fields: valid, write, addr, ready, data. Each clock, stage s moves to s+1 in the same lane, and stage 0 loads {iss_valid & ~flush, iss_write, iss_addr, ready=0}.
- Insert: when ins_valid[l] targets a valid, not-ready entry at stage s, the entry carries ready=1 and data=ins_data into s+1, or into the wb registers when s = DEPTH-1. An insert to an invalid entry or an already-ready entry is ignored; the stored data is not overwritten.
- Write-back: the entry leaving stage DEPTH-1 loads the wb registers. wb_valid = valid & write & ready. If valid & write & ~ready, wb_valid is 0 and wb_error is set until reset.
- Flush: clears valid in stages 0..FLUSH_STAGE-1 of all lanes and suppresses the current issue. Inserts into killed entries are dropped. Older stages continue unaffected.
- Lookup, combinational, using registered state only; same-cycle inserts and issues are not visible:
  - Search order, youngest first: stage 0..DEPTH-1, then the wb registers. Within a stage, the highest lane wins.
  - A candidate must have valid & write and a matching addr.
  - If the youngest match is ready: src_fwd=1, src_data = its data.
  - If the youngest match is unready: src_hazard=1, src_fwd=0, src_data = src_rf_data.
  - If there is no match: src_data = src_rf_data, and both flags are 0.
  - An older ready match never overrides a younger unready match.
- Every register address is valid; there is no hardwired zero register.

## Timing
- Reset (asynchronous): all entries invalid, wb_valid=0, wb_addr=0, wb_data=0, wb_error=0. As a result src_fwd=0, src_hazard=0, and src_data equals src_rf_data.
- Issue at edge N: entry sits in stage k during cycle N+k and in the wb registers during cycle N+DEPTH.
- A result inserted at stage s in cycle N+s is forwardable from cycle N+s+1 onward.
- Issue and flush in the same cycle: the issue is dropped.
- Insert on the final stage and exit in the same cycle: the inserted data appears in wb.
- Reset asserted mid-flight: all entries are discarded immediately; no write-back occurs.

## Structure
- Package pipe_fwd_pkg: entry_t struct (valid, write, ready, addr, data, sized from package constants) and default-parameter constants shared with Pipes.
- Sub-module pipe_fwd_lookup: priority search over the flattened entry array for one source. The top level instantiates NUM_SRC copies; it owns the shift, insert and flush logic.

## Test plan
- Reset with src_addr=5 and src_rf_data=0xAA…: src_data=0xAA…, flags 0, wb_valid=0. Release reset, idle 10 cycles: no wb_valid.
- Issue lane 0, addr 12, then insert 0x1234 at stage 3: src_hazard=1 for addr 12 during cycles 0–3; src_fwd=1 with 0x1234 from cycle 4; wb_valid[0] with addr 12 and 0x1234 at cycle 7.
- Issue addr 9 on both lanes in the same cycle, with lane-1 data inserted and lane-0 data pending: lane-1 data is forwarded; lane-0 data never wins the lookup.
- Issue addr 3 (ready, 0x11), then addr 3 again unready one cycle later: src_hazard=1 and 0x11 is not forwarded. Once the second result is inserted, its data is forwarded.
- Flush with entries in stages 0, 1 and 4 (FLUSH_STAGE=2): only the stage-4 entry writes back; a later insert targeting the killed stage-1 entry is ignored.
- Issue without any insert: wb_valid=0 at cycle 7 and wb_error=1, which stays set until reset.

Source files
------------

// File: rtl/pipe_fwd_pkg.sv
// Shared widths, default configuration and the tracked-entry record used by
// the forwarding tracker and the pipes that consume its write-back.
package pipe_fwd_pkg;

  localparam int P_LANES       = 2;
  localparam int P_DEPTH       = 7;
  localparam int P_NUM_SRC     = 6;
  localparam int P_FLUSH_STAGE = 2;
  localparam int DATA_W        = 128;
  localparam int ADDR_W        = 7;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/pipe_fwd_lookup.sv
// Youngest-first priority search of the in-flight entries for one operand.
// Candidate 0 is the youngest; an unready youngest match shadows older ones.
module pipe_fwd_lookup
  import pipe_fwd_pkg::*;
#(
  parameter int NCAND = 16
) (
  input  entry_t            cand_i [NCAND],
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              fwd_o,
  output logic              hazard_o
);

  logic   hit;
  entry_t sel;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    // Walk oldest to youngest so the last match taken is the youngest one.
    for (int i = NCAND - 1; i >= 0; i--) begin
      if (cand_i[i].valid && cand_i[i].write && (cand_i[i].addr == addr_i)) begin
        hit = 1'b1;
        sel = cand_i[i];
      end
    end
    fwd_o    = hit & sel.ready;
    hazard_o = hit & ~sel.ready;
    data_o   = (hit && sel.ready) ? sel.data : rf_data_i;
  end

endmodule

// File: rtl/pipe_forward_tracker.sv
// Per-lane shift register of in-flight results with completion-stage insert,
// branch flush, registered write-back and NUM_SRC forwarding lookups.
module pipe_forward_tracker
  import pipe_fwd_pkg::*;
#(
  parameter int  LANES       = P_LANES,
  parameter int  DEPTH       = P_DEPTH,
  parameter int  NUM_SRC     = P_NUM_SRC,
  parameter int  FLUSH_STAGE = P_FLUSH_STAGE,
  localparam int STG_W       = $clog2(DEPTH)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [LANES-1:0]                  iss_valid_i,
  input  logic [LANES-1:0][ADDR_W-1:0]      iss_addr_i,
  input  logic [LANES-1:0]                  iss_write_i,
  input  logic [LANES-1:0]                  ins_valid_i,
  input  logic [LANES-1:0][STG_W-1:0]       ins_stage_i,
  input  logic [LANES-1:0][DATA_W-1:0]      ins_data_i,
  input  logic                              flush_i,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]    src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_rf_data_i,
  output logic [NUM_SRC-1:0][DATA_W-1:0]    src_data_o,
  output logic [NUM_SRC-1:0]                src_fwd_o,
  output logic [NUM_SRC-1:0]                src_hazard_o,
  output logic [LANES-1:0]                  wb_valid_o,
  output logic [LANES-1:0][ADDR_W-1:0]      wb_addr_o,
  output logic [LANES-1:0][DATA_W-1:0]      wb_data_o,
  output logic                              wb_error_o
);

  localparam int NCAND = (DEPTH + 1) * LANES;

  entry_t pipe_q [LANES][DEPTH];
  entry_t pipe_d [LANES][DEPTH];
  entry_t adv    [LANES][DEPTH];
  entry_t wb_q   [LANES];
  entry_t wb_d   [LANES];
  entry_t cand   [NCAND];
  logic   wb_error_q, wb_error_d;

  // adv holds each stage after flush-kill and insert, i.e. what moves on.
  always_comb begin
    wb_error_d = wb_error_q;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        adv[l][s] = pipe_q[l][s];
        if (flush_i && (s < FLUSH_STAGE)) adv[l][s].valid = 1'b0;
        if (ins_valid_i[l] && (int'(ins_stage_i[l]) == s) &&
            adv[l][s].valid && !adv[l][s].ready) begin
          adv[l][s].ready = 1'b1;
          adv[l][s].data  = ins_data_i[l];
        end
      end
      pipe_d[l][0].valid = iss_valid_i[l] & ~flush_i;
      pipe_d[l][0].write = iss_write_i[l];
      pipe_d[l][0].ready = 1'b0;
      pipe_d[l][0].addr  = iss_addr_i[l];
      pipe_d[l][0].data  = '0;
      for (int s = 1; s < DEPTH; s++) pipe_d[l][s] = adv[l][s-1];
      wb_d[l] = adv[l][DEPTH-1];
      if (wb_d[l].valid && wb_d[l].write && !wb_d[l].ready) wb_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) pipe_q[l][s] <= '0;
        wb_q[l] <= '0;
      end
      wb_error_q <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) pipe_q[l][s] <= pipe_d[l][s];
        wb_q[l] <= wb_d[l];
      end
      wb_error_q <= wb_error_d;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wb_valid_o[l] = wb_q[l].valid & wb_q[l].write & wb_q[l].ready;
      wb_addr_o[l]  = wb_q[l].addr;
      wb_data_o[l]  = wb_q[l].data;
    end
    wb_error_o = wb_error_q;
  end

  // Youngest first: stage 0 upward, higher lane before lower, wb last.
  always_comb begin
    for (int s = 0; s < DEPTH; s++)
      for (int l = 0; l < LANES; l++)
        cand[s*LANES + (LANES-1-l)] = pipe_q[l][s];
    for (int l = 0; l < LANES; l++)
      cand[DEPTH*LANES + (LANES-1-l)] = wb_q[l];
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    pipe_fwd_lookup #(.NCAND(NCAND)) u_lookup (
      .cand_i    (cand),
      .addr_i    (src_addr_i[i]),
      .rf_data_i (src_rf_data_i[i]),
      .data_o    (src_data_o[i]),
      .fwd_o     (src_fwd_o[i]),
      .hazard_o  (src_hazard_o[i])
    );
  end

endmodule
